// File: rtl/axis_layer_collector.sv
// axis_layer_collector: packs a serial stream of NUM_WORDS activation words into a
// parallel bank, then raises layer_valid with a one-cycle layer_start pulse.
// Latency: bank complete (layer_valid/layer_start) one cycle after the last beat.
// Backpressure: s_tready is low while the bank is held (HOLD) until layer_ack.
// Ports: clk, reset (sync, active-high), s_tdata/s_tvalid/s_tready (input stream),
//        layer_data/layer_valid/layer_start/layer_ack (bank side), word_count.
// Option: define LAYER_COLLECTOR_RELU_EN to clamp negative words to zero on capture.
module axis_layer_collector #(
  parameter int NUM_WORDS = 18,
  parameter int DATA_W    = 32,
  localparam int CNT_W    = $clog2(NUM_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  output logic [NUM_WORDS*DATA_W-1:0] layer_data,
  output logic                        layer_valid,
  output logic                        layer_start,
  input  logic                        layer_ack,
  output logic [CNT_W-1:0]            word_count
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] bank_q [NUM_WORDS];

  logic              beat;
  logic              last_beat;
  logic [DATA_W-1:0] wr_dat;

  // Ready comes only from registered state, so it never depends on s_tvalid.
  assign s_tready  = (state_q == FILL) && !reset;
  assign beat      = s_tvalid && s_tready;
  assign last_beat = beat && (cnt_q == CNT_W'(NUM_WORDS - 1));

`ifdef LAYER_COLLECTOR_RELU_EN
  // Sign bit set means negative: store zero instead.
  assign wr_dat = s_tdata[DATA_W-1] ? '0 : s_tdata;
`else
  assign wr_dat = s_tdata;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    case (state_q)
      FILL: begin
        // layer_ack is deliberately ignored here, including on the last beat.
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = HOLD;
            start_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (layer_ack) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  // Bank is not cleared on ack: old words stay visible until overwritten.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (reset) begin
        bank_q[k] <= '0;
      end else if (beat && (cnt_q == CNT_W'(k))) begin
        bank_q[k] <= wr_dat;
      end
    end
  end

  always_comb begin
    layer_data = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      layer_data[k*DATA_W +: DATA_W] = bank_q[k];
    end
  end

  assign layer_valid = (state_q == HOLD);
  assign layer_start = start_q;
  assign word_count  = cnt_q;

endmodule

// File: tb/tb_axis_layer_collector.sv
module tb_axis_layer_collector;

  localparam int NW = 18;
  localparam int DW = 32;
  localparam int CW = $clog2(NW + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [NW*DW-1:0]  layer_data;
  logic              layer_valid;
  logic              layer_start;
  logic              layer_ack;
  logic [CW-1:0]     word_count;

  axis_layer_collector #(.NUM_WORDS(NW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .layer_data  (layer_data),
    .layer_valid (layer_valid),
    .layer_start (layer_start),
    .layer_ack   (layer_ack),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Frame state as plain variables: how many words have arrived, whether the
  // frame is complete and waiting for an ack, and the stored words.
  int          m_cnt = 0;
  bit          m_full = 1'b0;
  bit          m_start = 1'b0;
  logic [31:0] m_bank [NW];

  function automatic logic [31:0] store_val(input logic [31:0] d);
`ifdef LAYER_COLLECTOR_RELU_EN
    if ($signed(d) < 0) return 32'd0;
`endif
    return d;
  endfunction

  initial for (int k = 0; k < NW; k++) m_bank[k] = '0;

  always @(posedge clk) begin
    m_start = 1'b0;
    if (reset) begin
      m_cnt  = 0;
      m_full = 1'b0;
      for (int k = 0; k < NW; k++) m_bank[k] = '0;
    end else if (!m_full) begin
      if (s_tvalid) begin
        m_bank[m_cnt] = store_val(s_tdata);
        m_cnt++;
        if (m_cnt == NW) begin
          m_full  = 1'b1;
          m_start = 1'b1;
        end
      end
    end else if (layer_ack) begin
      m_full = 1'b0;
      m_cnt  = 0;
    end
  end

  // ---------------- checking ----------------
  int vecs = 0;
  int errs = 0;
  int starts = 0;

  task automatic chk(input string name, input logic [NW*DW-1:0] act, input logic [NW*DW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return layer_data[k*DW +: DW];
  endfunction

  // Called once per cycle at the falling edge: all outputs versus the model.
  task automatic model_check();
    logic [NW*DW-1:0] exp_data;
    for (int k = 0; k < NW; k++) exp_data[k*DW +: DW] = m_bank[k];
    chk("s_tready",    s_tready,    !m_full && !reset);
    chk("layer_valid", layer_valid, m_full);
    chk("layer_start", layer_start, m_start);
    chk("word_count",  word_count,  m_cnt);
    chk("layer_data",  layer_data,  exp_data);
    if (layer_start) starts++;
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic a);
    s_tvalid  = v;
    s_tdata   = d;
    layer_ack = a;
    @(negedge clk);
    model_check();
  endtask

  initial begin
    int base;
    logic [31:0] relu_in [4];
    logic [31:0] relu_exp [4];
    relu_in[0] = 32'hFFFF_FFFF; relu_in[1] = 32'h8000_0000;
    relu_in[2] = 32'h7FFF_FFFF; relu_in[3] = 32'd5;
`ifdef LAYER_COLLECTOR_RELU_EN
    relu_exp[0] = 32'd0; relu_exp[1] = 32'd0;
`else
    relu_exp[0] = 32'hFFFF_FFFF; relu_exp[1] = 32'h8000_0000;
`endif
    relu_exp[2] = 32'h7FFF_FFFF; relu_exp[3] = 32'd5;

    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; layer_ack = 1'b0;
    @(negedge clk);
    model_check();
    chk("reset_tready", s_tready, 1'b0);
    cyc(0, 0, 0);
    reset = 1'b0;
    cyc(0, 0, 0);
    chk("reset_data", layer_data, '0);
    chk("reset_count", word_count, 0);

    // Full-rate frame 0..17.
    base = starts;
    for (int k = 0; k < NW; k++) begin
      chk("stream_tready", s_tready, 1'b1);
      cyc(1, k, 0);
    end
    chk("frame1_start_now", layer_start, 1'b1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);
    chk("frame1_starts", starts - base, 1);
    chk("frame1_valid", layer_valid, 1'b1);
    chk("frame1_tready", s_tready, 1'b0);
    for (int k = 0; k < NW; k++) chk("frame1_word", word(k), k);

    // Backpressure: data held while full, captured right after ack.
    for (int i = 0; i < 3; i++) cyc(1, 32'h100, 0);
    chk("bp_word0_kept", word(0), 32'd0);
    chk("bp_count", word_count, NW);
    cyc(1, 32'h100, 1);
    chk("bp_tready_after_ack", s_tready, 1'b1);
    chk("bp_valid_after_ack", layer_valid, 1'b0);
    cyc(1, 32'h100, 0);
    chk("bp_word0", word(0), 32'h100);
    chk("bp_count1", word_count, 1);
    chk("bp_word1_old", word(1), 32'd1);
    base = starts;
    for (int k = 1; k < NW; k++) cyc(1, 32'h200 + k, 0);
    cyc(0, 0, 0);
    chk("bp_starts", starts - base, 1);

    // Gapped stream 1000+k.
    cyc(0, 0, 1);
    base = starts;
    for (int k = 0; k < NW; k++) begin
      cyc(1, 1000 + k, 0);
      cyc(0, 32'hDEAD, 0);
    end
    chk("gap_starts", starts - base, 1);
    for (int k = 0; k < NW; k++) chk("gap_word", word(k), 1000 + k);

    // Reset mid-frame after 7 beats.
    cyc(0, 0, 1);
    for (int k = 0; k < 7; k++) cyc(1, 32'h55 + k, 0);
    chk("mid_count7", word_count, 7);
    reset = 1'b1;
    cyc(1, 32'h77, 0);
    reset = 1'b0;
    chk("mid_reset_data", layer_data, '0);
    chk("mid_reset_count", word_count, 0);
    base = starts;
    for (int k = 0; k < NW; k++) cyc(1, 32'hA0 + k, 0);
    cyc(0, 0, 0);
    chk("mid_starts", starts - base, 1);
    for (int k = 0; k < NW; k++) chk("mid_word", word(k), 32'hA0 + k);

    // Ack on the last-beat cycle, held two more cycles.
    cyc(0, 0, 1);
    base = starts;
    for (int k = 0; k < NW - 1; k++) cyc(1, 32'h300 + k, 0);
    cyc(1, 32'h300 + NW - 1, 1);
    chk("ackl_hold_entered", layer_valid, 1'b1);
    cyc(0, 0, 1);
    chk("ackl_released", layer_valid, 1'b0);
    cyc(0, 0, 1);
    chk("ackl_fill_tready", s_tready, 1'b1);
    chk("ackl_fill_count", word_count, 0);
    cyc(0, 0, 0);
    chk("ackl_starts", starts - base, 1);

    // ReLU vectors (bit-exact when the option is off).
    for (int k = 0; k < NW; k++) cyc(1, (k < 4) ? relu_in[k] : 32'(k), 0);
    cyc(0, 0, 0);
    for (int k = 0; k < 4; k++) chk("relu_word", word(k), relu_exp[k]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
